nco_tdm_demux: RTL and testbench

NCO_TDM_DEMUX -- requirements
Module: nco_tdm_demux

---
 rtl/nco_demux_pkg.sv | 14 +
 rtl/nco_demux_obuf.sv | 95 +++++++++
 rtl/nco_tdm_demux.sv | 92 +++++++++
 tb/tb_nco_tdm_demux.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_demux_pkg.sv
// Shared constants for the NCO TDM demultiplexer.
package nco_demux_pkg;

   localparam int unsigned DEF_DATA_W = 14;
   localparam int unsigned DEF_NUM_CH = 2;
   localparam int unsigned CH_W       = $clog2(DEF_NUM_CH);
   localparam int unsigned CNT_W      = 16;

   // Channel-index width for an arbitrary channel count (at least one bit).
   function automatic int unsigned ch_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nco_demux_obuf.sv
// Output frame buffer with valid/ready handshake and sticky overflow.
// Optional frame/drop statistics counters when NCO_DEMUX_STATS_EN is defined.
module nco_demux_obuf
   import nco_demux_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned NUM_CH = DEF_NUM_CH
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     load,
   input  logic [NUM_CH*DATA_W-1:0] load_sin,
   input  logic [NUM_CH*DATA_W-1:0] load_cos,
   input  logic                     frame_ready,
   output logic                     frame_valid,
   output logic [NUM_CH*DATA_W-1:0] frame_sin,
   output logic [NUM_CH*DATA_W-1:0] frame_cos,
`ifdef NCO_DEMUX_STATS_EN
   output logic [CNT_W-1:0]         frame_cnt,
   output logic [CNT_W-1:0]         drop_cnt,
`endif
   output logic                     overflow
);

   logic                     valid_q, valid_d;
   logic                     ovf_q, ovf_d;
   logic [NUM_CH*DATA_W-1:0] sin_q, sin_d;
   logic [NUM_CH*DATA_W-1:0] cos_q, cos_d;
   logic                     accept;

   // Next-state: a completed frame loads if the buffer is free or draining this cycle,
   // otherwise it is dropped and the old frame kept.
   always_comb begin
      accept  = valid_q && frame_ready;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      sin_d   = sin_q;
      cos_d   = cos_q;
      if (load) begin
         if (!valid_q || frame_ready) begin
            valid_d = 1'b1;
            sin_d   = load_sin;
            cos_d   = load_cos;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

   // Buffer state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         sin_q   <= '0;
         cos_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         sin_q   <= sin_d;
         cos_q   <= cos_d;
      end
   end

   assign frame_valid = valid_q;
   assign frame_sin   = sin_q;
   assign frame_cos   = cos_q;
   assign overflow    = ovf_q;

`ifdef NCO_DEMUX_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             drop;
   logic [CNT_W-1:0] frame_cnt_q, drop_cnt_q;

   assign drop = load && valid_q && !frame_ready;

   // Saturating counters of accepted and dropped frames.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (accept && (frame_cnt_q != CNT_MAX)) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
         if (drop && (drop_cnt_q != CNT_MAX))    drop_cnt_q  <= drop_cnt_q + CNT_W'(1);
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: rtl/nco_tdm_demux.sv
// Demultiplexes an interleaved multi-channel NCO sample stream into parallel frames.
// Define NCO_DEMUX_STATS_EN to add frame_cnt/drop_cnt statistics outputs.
module nco_tdm_demux
   import nco_demux_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned NUM_CH = DEF_NUM_CH
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clken,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_sin,
   input  logic [DATA_W-1:0]        in_cos,
   input  logic                     resync,
   output logic                     frame_valid,
   input  logic                     frame_ready,
   output logic [NUM_CH*DATA_W-1:0] frame_sin,
   output logic [NUM_CH*DATA_W-1:0] frame_cos,
`ifdef NCO_DEMUX_STATS_EN
   output logic [CNT_W-1:0]         frame_cnt,
   output logic [CNT_W-1:0]         drop_cnt,
`endif
   output logic                     overflow
);

   localparam int unsigned IDX_W = ch_width(NUM_CH);

   logic [IDX_W-1:0]         ch_idx_q, ch_idx_d, wr_idx;
   logic [NUM_CH*DATA_W-1:0] slot_sin_q, slot_sin_d;
   logic [NUM_CH*DATA_W-1:0] slot_cos_q, slot_cos_d;
   logic                     capture, complete;

   // Collection next-state: resync forces the write slot to 0; the last slot completes a frame.
   // slot_*_d already holds the just-captured sample, so it doubles as the frame to load.
   always_comb begin
      capture    = in_valid && clken;
      wr_idx     = resync ? '0 : ch_idx_q;
      ch_idx_d   = ch_idx_q;
      slot_sin_d = slot_sin_q;
      slot_cos_d = slot_cos_q;
      complete   = 1'b0;
      if (capture) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               slot_sin_d[i*DATA_W +: DATA_W] = in_sin;
               slot_cos_d[i*DATA_W +: DATA_W] = in_cos;
            end
         end
         if (wr_idx == IDX_W'(NUM_CH - 1)) begin
            complete = 1'b1;
            ch_idx_d = '0;
         end else begin
            ch_idx_d = wr_idx + IDX_W'(1);
         end
      end
   end

   // Collection state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ch_idx_q   <= '0;
         slot_sin_q <= '0;
         slot_cos_q <= '0;
      end else begin
         ch_idx_q   <= ch_idx_d;
         slot_sin_q <= slot_sin_d;
         slot_cos_q <= slot_cos_d;
      end
   end

   nco_demux_obuf #(
      .DATA_W (DATA_W),
      .NUM_CH (NUM_CH)
   ) u_obuf (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (complete),
      .load_sin    (slot_sin_d),
      .load_cos    (slot_cos_d),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .frame_sin   (frame_sin),
      .frame_cos   (frame_cos),
`ifdef NCO_DEMUX_STATS_EN
      .frame_cnt   (frame_cnt),
      .drop_cnt    (drop_cnt),
`endif
      .overflow    (overflow)
   );

endmodule

// File: tb/tb_nco_tdm_demux.sv
// Self-checking bench for nco_tdm_demux: queue-based frame model plus directed literal checks.
module tb_nco_tdm_demux;

   localparam int DATA_W = 14;
   localparam int NUM_CH = 2;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic                     clken;
   logic                     in_valid;
   logic [DATA_W-1:0]        in_sin;
   logic [DATA_W-1:0]        in_cos;
   logic                     resync;
   logic                     frame_valid;
   logic                     frame_ready;
   logic [NUM_CH*DATA_W-1:0] frame_sin;
   logic [NUM_CH*DATA_W-1:0] frame_cos;
   logic                     overflow;
`ifdef NCO_DEMUX_STATS_EN
   logic [15:0]              frame_cnt;
   logic [15:0]              drop_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   nco_tdm_demux #(
      .DATA_W (DATA_W),
      .NUM_CH (NUM_CH)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clken       (clken),
      .in_valid    (in_valid),
      .in_sin      (in_sin),
      .in_cos      (in_cos),
      .resync      (resync),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_sin   (frame_sin),
      .frame_cos   (frame_cos),
`ifdef NCO_DEMUX_STATS_EN
      .frame_cnt   (frame_cnt),
      .drop_cnt    (drop_cnt),
`endif
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   int q_sin[$];
   int q_cos[$];
   int exp_sin[NUM_CH];
   int exp_cos[NUM_CH];
   bit exp_valid;
   bit exp_ovf;
   int exp_frame_cnt;
   int exp_drop_cnt;

   function automatic int sx(input logic [DATA_W-1:0] v);
      logic signed [DATA_W-1:0] t;
      t = v;
      return int'(t);
   endfunction

   function automatic int get_sin(input int ch);
      logic [DATA_W-1:0] t;
      t = frame_sin[ch*DATA_W +: DATA_W];
      return sx(t);
   endfunction

   function automatic int get_cos(input int ch);
      logic [DATA_W-1:0] t;
      t = frame_cos[ch*DATA_W +: DATA_W];
      return sx(t);
   endfunction

   task automatic model_step();
      bit accepted;
      bit done;
      int f_sin[NUM_CH];
      int f_cos[NUM_CH];
      if (!reset_n) begin
         q_sin.delete();
         q_cos.delete();
         for (int i = 0; i < NUM_CH; i++) begin
            exp_sin[i] = 0;
            exp_cos[i] = 0;
         end
         exp_valid     = 1'b0;
         exp_ovf       = 1'b0;
         exp_frame_cnt = 0;
         exp_drop_cnt  = 0;
         return;
      end
      accepted = exp_valid && frame_ready;
      done     = 1'b0;
      if (in_valid && clken) begin
         if (resync) begin
            q_sin.delete();
            q_cos.delete();
         end
         q_sin.push_back(sx(in_sin));
         q_cos.push_back(sx(in_cos));
         if (q_sin.size() == NUM_CH) begin
            done = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
               f_sin[i] = q_sin[i];
               f_cos[i] = q_cos[i];
            end
            q_sin.delete();
            q_cos.delete();
         end
      end
      if (done) begin
         if (!exp_valid || frame_ready) begin
            exp_valid = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
               exp_sin[i] = f_sin[i];
               exp_cos[i] = f_cos[i];
            end
         end else begin
            exp_ovf = 1'b1;
            if (exp_drop_cnt != 65535) exp_drop_cnt++;
         end
      end else if (accepted) begin
         exp_valid = 1'b0;
      end
      if (accepted && exp_frame_cnt != 65535) exp_frame_cnt++;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("model frame_valid", int'(frame_valid), int'(exp_valid));
         chk("model overflow", int'(overflow), int'(exp_ovf));
         for (int ch = 0; ch < NUM_CH; ch++) begin
            chk($sformatf("model sin ch%0d", ch), get_sin(ch), exp_sin[ch]);
            chk($sformatf("model cos ch%0d", ch), get_cos(ch), exp_cos[ch]);
         end
`ifdef NCO_DEMUX_STATS_EN
         chk("model frame_cnt", int'(frame_cnt), exp_frame_cnt);
         chk("model drop_cnt", int'(drop_cnt), exp_drop_cnt);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic send(input int s, input int c, input bit rs);
      in_valid = 1'b1;
      clken    = 1'b1;
      resync   = rs;
      in_sin   = DATA_W'(s);
      in_cos   = DATA_W'(c);
      cyc();
      in_valid = 1'b0;
      resync   = 1'b0;
   endtask

   initial begin
      reset_n     = 1'b0;
      clken       = 1'b1;
      in_valid    = 1'b0;
      resync      = 1'b0;
      in_sin      = '0;
      in_cos      = '0;
      frame_ready = 1'b0;
      cyc();
      cmp_en = 1'b1;
      cyc();
      chk("reset frame_valid", int'(frame_valid), 0);
      chk("reset overflow", int'(overflow), 0);
      chk("reset frame_sin", int'(frame_sin), 0);
      chk("reset frame_cos", int'(frame_cos), 0);

      // Basic two-channel frame with one-cycle latency.
      reset_n     = 1'b1;
      frame_ready = 1'b1;
      send(100, -100, 1'b0);
      chk("basic valid after ch0", int'(frame_valid), 0);
      send(200, -200, 1'b0);
      chk("basic valid", int'(frame_valid), 1);
      chk("basic sin ch0", get_sin(0), 100);
      chk("basic sin ch1", get_sin(1), 200);
      chk("basic cos ch0", get_cos(0), -100);
      chk("basic cos ch1", get_cos(1), -200);
      cyc();
      chk("basic accepted", int'(frame_valid), 0);

      // clken low with in_valid high captures nothing.
      frame_ready = 1'b0;
      send(1, -1, 1'b0);
      in_valid = 1'b1;
      clken    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_sin = DATA_W'(77 + i);
         in_cos = DATA_W'(-77 - i);
         cyc();
         chk("clken0 valid", int'(frame_valid), 0);
      end
      send(2, -2, 1'b0);
      chk("clken0 frame valid", int'(frame_valid), 1);
      chk("clken0 sin ch0", get_sin(0), 1);
      chk("clken0 sin ch1", get_sin(1), 2);
      cyc();
      cyc();
      chk("hold sin ch0", get_sin(0), 1);
      chk("hold cos ch1", get_cos(1), -2);
      clken       = 1'b0;
      frame_ready = 1'b1;
      cyc();
      chk("handshake without clken", int'(frame_valid), 0);
      clken = 1'b1;

      // Completion while full and accepted in the same cycle replaces the frame.
      frame_ready = 1'b0;
      send(3, -3, 1'b0);
      send(4, -4, 1'b0);
      send(5, -5, 1'b0);
      frame_ready = 1'b1;
      send(6, -6, 1'b0);
      chk("replace valid", int'(frame_valid), 1);
      chk("replace sin ch0", get_sin(0), 5);
      chk("replace sin ch1", get_sin(1), 6);
      chk("replace overflow", int'(overflow), 0);
      cyc();
      chk("replace accepted", int'(frame_valid), 0);

      // Resync on second sample discards the first.
      frame_ready = 1'b0;
      send(10, -10, 1'b0);
      send(20, -20, 1'b1);
      chk("resync no frame", int'(frame_valid), 0);
      send(30, -30, 1'b0);
      chk("resync valid", int'(frame_valid), 1);
      chk("resync sin ch0", get_sin(0), 20);
      chk("resync sin ch1", get_sin(1), 30);
      chk("resync cos ch0", get_cos(0), -20);
      frame_ready = 1'b1;
      cyc();

      // Three frames with no acceptance: first kept, two dropped.
      frame_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(11 + i, -11 - i, 1'b0);
      chk("ovf valid", int'(frame_valid), 1);
      chk("ovf sin ch0", get_sin(0), 11);
      chk("ovf sin ch1", get_sin(1), 12);
      chk("ovf overflow", int'(overflow), 1);
`ifdef NCO_DEMUX_STATS_EN
      chk("ovf drop_cnt", int'(drop_cnt), 2);
      chk("ovf frame_cnt", int'(frame_cnt), 5);
`endif
      frame_ready = 1'b1;
      cyc();
      chk("overflow sticky", int'(overflow), 1);

      // Reset mid-frame, then full-scale samples.
      send(9, -9, 1'b0);
      reset_n = 1'b0;
      cyc();
      reset_n     = 1'b1;
      frame_ready = 1'b0;
      chk("post-reset overflow", int'(overflow), 0);
      chk("post-reset valid", int'(frame_valid), 0);
      send(8191, -8192, 1'b0);
      send(-8192, 8191, 1'b0);
      chk("fullscale valid", int'(frame_valid), 1);
      chk("fullscale sin ch0", get_sin(0), 8191);
      chk("fullscale sin ch1", get_sin(1), -8192);
      chk("fullscale cos ch0", get_cos(0), -8192);
      chk("fullscale cos ch1", get_cos(1), 8191);
      cyc();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
